cdb_arbiter: RTL
================

# cdb_arbiter

Completion-stage arbiter between the functional units (ALU, multiplier, load/store) and the common data bus. Each FU pushes finished instructions into a small per-source FIFO. One completion per cycle is granted round-robin and broadcast as the CDB tag, which wakes reservation-station operands and marks ROB completion. The same grant drives the reservation-station remove request for the finished entry.

## Interface
Parameters:
- NUM_SRC, 3: number of completing FUs (0 = ALU, 1 = MULT, 2 = LSU)
- FIFO_DEPTH, 2: entries per source FIFO, power of two ≥ 2
- PREG_W, 6: physical-register tag width
- RS_IDX_W, 3: reservation-station index width
- ROB_IDX_W, 5: ROB index width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- squash  in  1  mispredict flush; discards all buffered completions
- src_valid  in  NUM_SRC  FU presents a completion
- src_ready  out  NUM_SRC  FIFO can accept this cycle
- src_has_dest  in  NUM_SRC  completion writes a physical register
- src_preg  in  NUM_SRC×PREG_W  destination tag
- src_rs_idx  in  NUM_SRC×RS_IDX_W  RS entry to free
- src_rob_idx  in  NUM_SRC×ROB_IDX_W  ROB entry completing
- complete_en  out  1  a completion is granted this cycle
- cdb_en  out  1  complete_en & has_dest of the granted entry
- cdb_tag  out  PREG_W  broadcast physical tag
- cdb_rob_idx  out  ROB_IDX_W  ROB entry to mark complete
- remove_en  out  1  equals complete_en
- remove_idx  out  RS_IDX_W  RS entry to clear

## Operation
- Push: accept on src_valid[i] & src_ready[i]. The FIFO stores {has_dest, preg, rs_idx, rob_idx}.
- src_ready[i] = (count[i] < FIFO_DEPTH) & !squash. It is computed from registered state only. A pop in the same cycle does not raise ready.
- Arbitration (combinational): scan sources starting at rr_ptr, wrapping modulo NUM_SRC. The first non-empty FIFO wins. With no non-empty FIFO, complete_en = 0.
- Grant: the head of the winning FIFO drives all outputs. That head pops at the clock edge, and rr_ptr becomes (grant+1) mod NUM_SRC. With no grant, rr_ptr holds.
- If has_dest = 0 (store, branch): complete_en = 1, cdb_en = 0, and cdb_tag is still driven from the entry.
- Outputs are all 0 whenever complete_en = 0.
- Squash: complete_en, cdb_en and remove_en are forced to 0 and no push is accepted. At the edge all counts, head and tail pointers reset to 0 and rr_ptr resets to 0.
- Simultaneous push and pop on one FIFO: count is unchanged and the pointers both advance. The tail pointer wraps modulo FIFO_DEPTH, and so does the head pointer.
- Overflow cannot occur. A push while full is ignored, and FUs must hold src_valid until they see ready.

## Timing
- Latency: a completion accepted at edge N is visible on the outputs in cycle N+1 if its FIFO is granted, which is the minimum latency. There is no same-cycle bypass.
- Throughput: one completion per cycle in total.
- Fairness: each non-empty source is granted within NUM_SRC cycles.
- Reset values: all counts = 0, rr_ptr = 0, src_ready all 1 in the cycle after reset, and all outputs 0.
- Reset or squash in the middle of a stream: completions buffered but not yet granted are dropped without a broadcast.
- Reset has priority over squash.

## Structure
- Shared package (sys_defs):
  - CDB_PACKET typedef {has_dest, preg, rs_idx, rob_idx}
  - FU index constants FU_ALU, FU_MULT and FU_LSU
- Sub-module cdb_fifo: a parameterised synchronous FIFO.
  - Ports: push, pop, flush, data in and out, count/full/empty.
  - Instantiated NUM_SRC times.
- The arbiter, rr_ptr register and output mux live in cdb_arbiter.

## Test plan
- Single ALU push {has_dest=1, preg=12, rs_idx=2, rob_idx=7} at edge 0 → cycle 1: complete_en = cdb_en = remove_en = 1, cdb_tag = 12, remove_idx = 2, cdb_rob_idx = 7. Cycle 2: all outputs 0.
- All three sources push every cycle for 6 cycles, rr_ptr = 0 → grants 0,1,2,0,1,2. The FIFOs fill, src_ready drops to 0 for each source when its count = 2, and no entries are lost.
- LSU store {has_dest=0, rs_idx=5} → complete_en = 1, remove_idx = 5, cdb_en = 0.
- Fill MULT FIFO to 2, assert squash one cycle → outputs 0 that cycle, counts 0 next cycle, src_ready all 1, no broadcast of the dropped entries.
- One-entry FIFO: push and pop in the same cycle → count stays 1 and the next head is the newly pushed tag. Run 20 cycles of this to check pointer wrap at FIFO_DEPTH.
- Assert reset while entries are buffered → next cycle all outputs 0, rr_ptr = 0, and the first grant after reset comes from source 0 when all sources are pending.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | Package  : sys_defs                                              |
// | Desc.    : Shared CDB completion packet type and FU indices.     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package sys_defs;

  localparam int CDB_NUM_SRC    = 3;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int CDB_PREG_W     = 6;
  localparam int CDB_RS_IDX_W   = 3;
  localparam int CDB_ROB_IDX_W  = 5;

  localparam int FU_ALU  = 0;
  localparam int FU_MULT = 1;
  localparam int FU_LSU  = 2;

  typedef struct packed {
    logic                     has_dest;
    logic [CDB_PREG_W-1:0]    preg;
    logic [CDB_RS_IDX_W-1:0]  rs_idx;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
  } CDB_PACKET;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// +------------------------------------------------------------------+
// | Interface : cdb_arbiter_if                                       |
// | Desc.     : FU completion push side and CDB/RS broadcast side.   |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

interface cdb_arbiter_if #(
  parameter int NUM_SRC   = sys_defs::CDB_NUM_SRC,
  parameter int PREG_W    = sys_defs::CDB_PREG_W,
  parameter int RS_IDX_W  = sys_defs::CDB_RS_IDX_W,
  parameter int ROB_IDX_W = sys_defs::CDB_ROB_IDX_W
);

  logic                               squash;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC-1:0]                 src_has_dest;
  logic [NUM_SRC-1:0][PREG_W-1:0]     src_preg;
  logic [NUM_SRC-1:0][RS_IDX_W-1:0]   src_rs_idx;
  logic [NUM_SRC-1:0][ROB_IDX_W-1:0]  src_rob_idx;
  logic                               complete_en;
  logic                               cdb_en;
  logic [PREG_W-1:0]                  cdb_tag;
  logic [ROB_IDX_W-1:0]               cdb_rob_idx;
  logic                               remove_en;
  logic [RS_IDX_W-1:0]                remove_idx;

  modport master (
    output squash, src_valid, src_has_dest, src_preg, src_rs_idx, src_rob_idx,
    input  src_ready, complete_en, cdb_en, cdb_tag, cdb_rob_idx, remove_en, remove_idx
  );

  modport slave (
    input  squash, src_valid, src_has_dest, src_preg, src_rs_idx, src_rob_idx,
    output src_ready, complete_en, cdb_en, cdb_tag, cdb_rob_idx, remove_en, remove_idx
  );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
// +------------------------------------------------------------------+
// | Module   : cdb_fifo                                              |
// | Desc.    : Small synchronous FIFO buffering one FU's completions. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module cdb_fifo #(
  parameter  int WIDTH = 15,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign data_out = r_mem[r_head];
  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= data_in;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +------------------------------------------------------------------+
// | Module   : cdb_arbiter                                           |
// | Desc.    : Round-robin completion arbiter driving CDB and RS free.|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int PREG_W     = CDB_PREG_W,
  parameter int RS_IDX_W   = CDB_RS_IDX_W,
  parameter int ROB_IDX_W  = CDB_ROB_IDX_W
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam int c_SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int c_ENTRY_W = 1 + PREG_W + RS_IDX_W + ROB_IDX_W;
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                 has_dest;
    logic [PREG_W-1:0]    preg;
    logic [RS_IDX_W-1:0]  rs_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } entry_t;

  entry_t               w_push_data [NUM_SRC];
  entry_t               w_head      [NUM_SRC];
  logic [c_CNT_W-1:0]   w_count     [NUM_SRC];
  logic [NUM_SRC-1:0]   w_full;
  logic [NUM_SRC-1:0]   w_empty;
  logic [NUM_SRC-1:0]   w_push;
  logic [NUM_SRC-1:0]   w_pop;
  logic [NUM_SRC-1:0]   w_unused_count;
  logic [c_SRC_W-1:0]   r_rr_ptr;
  logic [c_SRC_W-1:0]   w_grant_idx;
  logic                 w_grant_vld;
  logic                 w_grant_en;
  entry_t               w_sel;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_push_data[i] = '{has_dest: bus.src_has_dest[i],
                                preg:     bus.src_preg[i],
                                rs_idx:   bus.src_rs_idx[i],
                                rob_idx:  bus.src_rob_idx[i]};
      // Ready comes from registered fullness only; a same-cycle pop does not help.
      assign bus.src_ready[i] = ~w_full[i] & ~bus.squash;
      assign w_push[i]        = bus.src_valid[i] & bus.src_ready[i];
      assign w_pop[i]         = w_grant_en & (w_grant_idx == c_SRC_W'(i));
      assign w_unused_count[i] = ^w_count[i];

      cdb_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (bus.squash),
        .push     (w_push[i]),
        .pop      (w_pop[i]),
        .data_in  (w_push_data[i]),
        .data_out (w_head[i]),
        .count    (w_count[i]),
        .full     (w_full[i]),
        .empty    (w_empty[i])
      );
    end
  endgenerate

  always_comb begin
    int s;
    s           = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (int'(r_rr_ptr) + k) % NUM_SRC;
      if (!w_grant_vld && !w_empty[s]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = c_SRC_W'(s);
      end
    end
  end

  assign w_grant_en = w_grant_vld & ~bus.squash;
  assign w_sel      = w_grant_en ? w_head[w_grant_idx] : '0;

  assign bus.complete_en = w_grant_en;
  assign bus.remove_en   = w_grant_en;
  assign bus.cdb_en      = w_sel.has_dest;
  assign bus.cdb_tag     = w_sel.preg;
  assign bus.cdb_rob_idx = w_sel.rob_idx;
  assign bus.remove_idx  = w_sel.rs_idx;

  always_ff @(posedge clock) begin
    if (reset || bus.squash) begin
      r_rr_ptr <= '0;
    end else if (w_grant_en) begin
      r_rr_ptr <= (w_grant_idx == c_SRC_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + c_SRC_W'(1);
    end
  end

endmodule

`default_nettype wire
